// File: rtl/tour_cmd_arb.sv
// ---------------------------------------------------------------------------
// tour_cmd_arb
//
// Arbitrates between two command sources (UART wrapper and tour sequencer)
// feeding a single command processor, then routes the completion back as a
// response byte on the UART transmitter and, for tour-owned commands, as a
// tour_resp pulse.
//
// Handshake semantics (all interfaces):
//   A source raises *_rdy_i with its word and holds both until the arbiter
//   pulses the matching clr_*_o for one cycle. cmd_rdy_o is held with a
//   stable cmd_o until clr_cmd_rdy_i is seen, and drops the next cycle.
//   send_resp_i is a one-cycle completion strobe, only honoured in BUSY.
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   uart_cmd_i/_rdy_i         UART command word and valid
//   clr_uart_cmd_rdy_o        one-cycle pulse consuming the UART command
//   tour_cmd_i/_rdy_i         tour command word and valid
//   clr_tour_cmd_rdy_o        one-cycle pulse consuming the tour command
//   tour_active_i             tour in progress; blocks UART grants
//   cmd_o, cmd_rdy_o          command and valid towards cmd_proc
//   clr_cmd_rdy_i             cmd_proc accepted cmd_o
//   send_resp_i               cmd_proc completed the command
//   tour_resp_o               pulse: tour-owned command completed
//   resp_o, trmt_o            response byte and its launch pulse
//   busy_o                    high whenever not IDLE
//   dbg_state_o               current FSM state
//   dbg_timeout_o             last completion was a timeout
// ---------------------------------------------------------------------------
module tour_cmd_arb #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] uart_cmd_i,
  input  logic        uart_cmd_rdy_i,
  output logic        clr_uart_cmd_rdy_o,
  input  logic [15:0] tour_cmd_i,
  input  logic        tour_cmd_rdy_i,
  output logic        clr_tour_cmd_rdy_o,
  input  logic        tour_active_i,
  output logic [15:0] cmd_o,
  output logic        cmd_rdy_o,
  input  logic        clr_cmd_rdy_i,
  input  logic        send_resp_i,
  output logic        tour_resp_o,
  output logic [7:0]  resp_o,
  output logic        trmt_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Counter value on the final BUSY cycle before a timeout: the limit is
  // 2^16 or 2^24 cycles, counted from zero on BUSY entry.
  localparam logic [23:0] CNT_LAST = FAST_SIM ? 24'h00FFFF : 24'hFFFFFF;

  localparam logic [7:0] RESP_TIMEOUT = 8'hEE;
  localparam logic [7:0] RESP_UART    = 8'hA5;
  localparam logic [7:0] RESP_TOUR    = 8'h5A;

  state_e      state_q;
  logic        owner_tour_q;
  logic [23:0] cnt_q;
  logic [23:0] cnt_d;
  logic        timeout_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        clr_uart_q;
  logic        clr_tour_q;
  logic [7:0]  resp_q;
  logic        trmt_q;
  logic        tour_resp_q;

  assign cnt_d = cnt_q + 24'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      owner_tour_q <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      clr_uart_q   <= 1'b0;
      clr_tour_q   <= 1'b0;
      resp_q       <= '0;
      trmt_q       <= 1'b0;
      tour_resp_q  <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for a single cycle below.
      clr_uart_q  <= 1'b0;
      clr_tour_q  <= 1'b0;
      trmt_q      <= 1'b0;
      tour_resp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Tour has priority; a UART request is left pending (not cleared)
          // whenever it loses or a tour is active.
          if (tour_cmd_rdy_i) begin
            cmd_q        <= tour_cmd_i;
            owner_tour_q <= 1'b1;
            clr_tour_q   <= 1'b1;
            cmd_rdy_q    <= 1'b1;
            state_q      <= S_GRANT;
          end else if (uart_cmd_rdy_i && !tour_active_i) begin
            cmd_q        <= uart_cmd_i;
            owner_tour_q <= 1'b0;
            clr_uart_q   <= 1'b1;
            cmd_rdy_q    <= 1'b1;
            state_q      <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (clr_cmd_rdy_i) begin
            cmd_rdy_q <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A completion on the same cycle as the limit counts as a
          // normal completion, not a timeout.
          if (send_resp_i) begin
            timeout_q   <= 1'b0;
            trmt_q      <= 1'b1;
            resp_q      <= owner_tour_q ? RESP_TOUR : RESP_UART;
            tour_resp_q <= owner_tour_q;
            state_q     <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            trmt_q    <= 1'b1;
            resp_q    <= RESP_TIMEOUT;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign clr_uart_cmd_rdy_o = clr_uart_q;
  assign clr_tour_cmd_rdy_o = clr_tour_q;
  assign cmd_o              = cmd_q;
  assign cmd_rdy_o          = cmd_rdy_q;
  assign resp_o             = resp_q;
  assign trmt_o             = trmt_q;
  assign tour_resp_o        = tour_resp_q;
  assign busy_o             = (state_q != S_IDLE);
  assign dbg_state_o        = state_q;
  assign dbg_timeout_o      = timeout_q;

endmodule

// File: tb/tb_tour_cmd_arb.sv
// ---------------------------------------------------------------------------
// tb_tour_cmd_arb: self-checking bench for tour_cmd_arb (FAST_SIM=1).
// Table-driven arbitration vectors, hand-written multi-cycle sequences,
// then randomized transactions checked against a rule-level model.
// ---------------------------------------------------------------------------
module tb_tour_cmd_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [15:0] uart_cmd = '0;
  logic        uart_rdy = 1'b0;
  logic        clr_uart;
  logic [15:0] tour_cmd = '0;
  logic        tour_rdy = 1'b0;
  logic        clr_tour;
  logic        tour_active = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        tour_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic        busy;
  logic [1:0]  dbg_state;
  logic        dbg_timeout;

  tour_cmd_arb #(.FAST_SIM(1'b1)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .uart_cmd_i         (uart_cmd),
    .uart_cmd_rdy_i     (uart_rdy),
    .clr_uart_cmd_rdy_o (clr_uart),
    .tour_cmd_i         (tour_cmd),
    .tour_cmd_rdy_i     (tour_rdy),
    .clr_tour_cmd_rdy_o (clr_tour),
    .tour_active_i      (tour_active),
    .cmd_o              (cmd),
    .cmd_rdy_o          (cmd_rdy),
    .clr_cmd_rdy_i      (clr_cmd_rdy),
    .send_resp_i        (send_resp),
    .tour_resp_o        (tour_resp),
    .resp_o             (resp),
    .trmt_o             (trmt),
    .busy_o             (busy),
    .dbg_state_o        (dbg_state),
    .dbg_timeout_o      (dbg_timeout)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];   // {tour_resp, resp} expected at each trmt
  logic [8:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every trmt must match the oldest expected response.
  always @(negedge clk) begin
    if (trmt) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_trmt: got trmt resp=%0h expected no trmt", resp);
      end else begin
        mon_e = exp_q.pop_front();
        if ({tour_resp, resp} !== mon_e) begin
          n_err++;
          $display("FAIL resp_sb: got %0h expected %0h", {tour_resp, resp}, mon_e);
        end
      end
    end
    if (tour_resp && !trmt) begin
      n_cmp++;
      n_err++;
      $display("FAIL tour_resp_alone: got tour_resp=1 expected 0 without trmt");
    end
  end

  // ---------------- reference model ----------------
  // Who should be granted from the arbitration rules: 1 = tour, 2 = uart, 0 = none.
  function automatic int pick(input bit t, input bit u, input bit act);
    if (t) return 1;
    if (u && !act) return 2;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic grant_wait(output int who, input int max_cyc);
    who = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick;
      if (clr_tour || clr_uart) begin
        who = clr_tour ? 1 : 2;
        chk("single_clr", 32'(clr_tour & clr_uart), 32'd0);
        if (clr_tour) tour_rdy = 1'b0;
        else uart_rdy = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'h0);
    chk({tag, "_resp"}, 32'(resp), 32'h0);
    chk({tag, "_outs"}, 32'({cmd_rdy, trmt, tour_resp, clr_uart, clr_tour, busy}), 32'h0);
    chk({tag, "_state"}, 32'({dbg_state, dbg_timeout}), 32'h0);
  endtask

  // Called at the negedge where the grant pulse is visible; drives the
  // cmd_proc side and checks the response phase.
  task automatic finish_cmd(input logic [15:0] exp_cmd, input logic [7:0] exp_resp,
                            input bit exp_tresp, input int d_clr, input int d_resp,
                            input bit flip_act);
    chk("grant_cmd", 32'(cmd), 32'(exp_cmd));
    chk("grant_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("grant_busy", 32'(busy), 32'd1);
    for (int i = 0; i < d_clr; i++) begin
      tick;
      chk("hold_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("hold_cmd", 32'(cmd), 32'(exp_cmd));
    end
    clr_cmd_rdy = 1'b1;
    tick;
    clr_cmd_rdy = 1'b0;
    chk("clr_pulse_len", 32'(clr_tour | clr_uart), 32'd0);
    chk("busy_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("busy_busy", 32'(busy), 32'd1);
    if (flip_act) tour_active = ~tour_active;
    for (int i = 0; i < d_resp; i++) begin
      tick;
      chk("busy_no_trmt", 32'(trmt), 32'd0);
    end
    exp_q.push_back({exp_tresp, exp_resp});
    send_resp = 1'b1;
    tick;
    send_resp = 1'b0;
    chk("resp_trmt", 32'(trmt), 32'd1);
    tick;
    chk("after_trmt", 32'(trmt), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("resp_hold", 32'(resp), 32'(exp_resp));
  endtask

  // ---------------- test ----------------
  typedef struct {
    bit          t;
    bit          u;
    bit          act;
    logic [15:0] tw;
    logic [15:0] uw;
    int          who;
    logic [15:0] cmd;
    logic [7:0]  resp;
    bit          tresp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int who;
    int ew;
    logic [15:0] ew_word;
    int n;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 16'h4002, 16'h2000, 2, 16'h2000, 8'hA5, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h4002, 16'h2000, 1, 16'h4002, 8'h5A, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h4002, 16'h2000, 1, 16'h4002, 8'h5A, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 1, 16'hFFFF, 8'h5A, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0, 16'h0000, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 0, 16'h0000, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 2, 16'hFFFF, 8'hA5, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h1234, 1, 16'h0000, 8'h5A, 1'b1};

    // reset
    rst_n = 1'b0;
    tick;
    tick;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick;

    // table-driven arbitration vectors
    for (int k = 0; k < 8; k++) begin
      tour_active = tbl[k].act;
      tour_cmd    = tbl[k].tw;
      uart_cmd    = tbl[k].uw;
      tour_rdy    = tbl[k].t;
      uart_rdy    = tbl[k].u;
      grant_wait(who, 3);
      chk("tbl_who", 32'(who), 32'(tbl[k].who));
      if (who != 0) finish_cmd(tbl[k].cmd, tbl[k].resp, tbl[k].tresp, 1, 2, 1'b0);
      else chk("tbl_idle", 32'(busy), 32'd0);
      tour_rdy    = 1'b0;
      uart_rdy    = 1'b0;
      tour_active = 1'b0;
    end

    // both ready with tour active, then release the pending UART request
    tour_active = 1'b1;
    uart_cmd = 16'h2000; uart_rdy = 1'b1;
    tour_cmd = 16'h4002; tour_rdy = 1'b1;
    grant_wait(who, 3);
    chk("both_who", 32'(who), 32'd1);
    if (who == 1) finish_cmd(16'h4002, 8'h5A, 1'b1, 0, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("uart_blocked", 32'({clr_uart, busy}), 32'd0);
    end
    tour_active = 1'b0;
    tick;
    chk("uart_release_clr", 32'(clr_uart), 32'd1);
    if (clr_uart) begin
      uart_rdy = 1'b0;
      finish_cmd(16'h2000, 8'hA5, 1'b0, 2, 0, 1'b0);
    end

    // tour_active drops mid-BUSY; pending UART granted only after RESP
    tour_active = 1'b1;
    tour_cmd = 16'h1234; tour_rdy = 1'b1;
    uart_cmd = 16'h5555; uart_rdy = 1'b1;
    grant_wait(who, 3);
    chk("mid_who", 32'(who), 32'd1);
    if (who == 1) begin
      finish_cmd(16'h1234, 8'h5A, 1'b1, 1, 3, 1'b1);
      chk("spacing_no_clr", 32'(clr_uart), 32'd0);
      tick;
      chk("spacing_clr", 32'(clr_uart), 32'd1);
      if (clr_uart) begin
        uart_rdy = 1'b0;
        finish_cmd(16'h5555, 8'hA5, 1'b0, 0, 0, 1'b0);
      end
    end
    uart_rdy = 1'b0;

    // stray send_resp / clr_cmd_rdy in IDLE
    send_resp = 1'b1; clr_cmd_rdy = 1'b1;
    tick;
    send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    chk("idle_ignore", 32'({busy, cmd_rdy, trmt, tour_resp, clr_uart, clr_tour, dbg_state}), 32'h0);
    tick;
    chk("idle_ignore2", 32'({busy, trmt}), 32'h0);

    // reset while in GRANT
    uart_cmd = 16'h0777; uart_rdy = 1'b1;
    grant_wait(who, 3);
    chk("rst_g_who", 32'(who), 32'd2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check_reset_vals("rst_grant");
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick; send_resp = 1'b0;
    tick;
    chk("rst_grant_no_trmt", 32'({trmt, busy}), 32'h0);

    // reset while in BUSY
    tour_cmd = 16'h0888; tour_rdy = 1'b1;
    grant_wait(who, 3);
    chk("rst_b_who", 32'(who), 32'd1);
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
    tick;
    chk("rst_b_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check_reset_vals("rst_busy");
    send_resp = 1'b1; tick; send_resp = 1'b0;
    tick;
    chk("rst_busy_no_trmt", 32'({trmt, tour_resp, busy}), 32'h0);

    // timeout: no send_resp after clr_cmd_rdy
    uart_cmd = 16'h2000; uart_rdy = 1'b1;
    grant_wait(who, 3);
    chk("to_who", 32'(who), 32'd2);
    clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
    exp_q.push_back({1'b0, 8'hEE});
    n = 0;
    while (!trmt && n < 70000) begin
      tick;
      n++;
    end
    chk("to_cycles", 32'(n), 32'd65536);
    chk("to_resp", 32'({tour_resp, resp}), 32'h0EE);
    tick;
    chk("to_after", 32'({busy, trmt}), 32'h0);
    chk("to_hold", 32'(resp), 32'hEE);

    // randomized transactions against the rule model
    for (int it = 0; it < 150; it++) begin
      if (!tour_rdy && $urandom_range(0, 2) == 0) begin
        tour_rdy = 1'b1;
        tour_cmd = 16'($urandom);
      end
      if (!uart_rdy && $urandom_range(0, 1) == 0) begin
        uart_rdy = 1'b1;
        uart_cmd = 16'($urandom);
      end
      tour_active = 1'($urandom_range(0, 1));
      ew = pick(tour_rdy, uart_rdy, tour_active);
      ew_word = (ew == 1) ? tour_cmd : uart_cmd;
      grant_wait(who, 3);
      chk("rnd_who", 32'(who), 32'(ew));
      if (ew != 0 && who == ew)
        finish_cmd(ew_word, (ew == 1) ? 8'h5A : 8'hA5, ew == 1,
                   $urandom_range(0, 3), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)));
    end

    tick;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tour_cmd_arb.md
TOUR_CMD_ARB -- requirements
Module: tour_cmd_arb

Interface
REQ-001 Parameter FAST_SIM, default 1; selects response-timeout length (REQ-019).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 uart_cmd  input  16  command word from UART_wrapper.
REQ-005 uart_cmd_rdy  input  1  UART command valid, held until cleared.
REQ-006 clr_uart_cmd_rdy  output  1  one-cycle pulse consuming uart_cmd.
REQ-007 tour_cmd  input  16  command word from tour sequencer.
REQ-008 tour_cmd_rdy  input  1  tour command valid, held until cleared.
REQ-009 clr_tour_cmd_rdy  output  1  one-cycle pulse consuming tour_cmd.
REQ-010 tour_active  input  1  high while a tour is in progress.
REQ-011 cmd  output  16  command presented to cmd_proc.
REQ-012 cmd_rdy  output  1  cmd valid to cmd_proc.
REQ-013 clr_cmd_rdy  input  1  cmd_proc accepted cmd.
REQ-014 send_resp  input  1  cmd_proc one-cycle pulse: command completed.
REQ-015 tour_resp  output  1  one-cycle pulse: tour-owned command completed.
REQ-016 resp  output  8  response byte to UART transmitter.
REQ-017 trmt  output  1  one-cycle pulse launching resp.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Timeout limit: 2^16 clocks when FAST_SIM=1, 2^24 when FAST_SIM=0; 24-bit counter, cleared on entry to BUSY.
REQ-020 States: IDLE, GRANT, BUSY, RESP; exactly one owner register (UART or TOUR) latched on leaving IDLE.
REQ-021 IDLE: if tour_cmd_rdy, grant TOUR; else if uart_cmd_rdy and tour_active low, grant UART; else stay.
REQ-022 Simultaneous tour_cmd_rdy and uart_cmd_rdy in IDLE: TOUR wins; UART request remains pending, not cleared.
REQ-023 While tour_active high, UART requests are never granted and never cleared.
REQ-024 Grant cycle: latch selected word into cmd, pulse matching clr_*_cmd_rdy for exactly one cycle, go to GRANT; non-selected clr stays low.
REQ-025 GRANT: cmd_rdy high, cmd stable; on clr_cmd_rdy go to BUSY, cmd_rdy low next cycle.
REQ-026 BUSY: on send_resp go to RESP; counter increments each cycle; counter reaching limit goes to RESP with timeout flag set.
REQ-027 send_resp outside BUSY is ignored.
REQ-028 RESP (one cycle): pulse trmt; resp = 8'hEE on timeout, 8'hA5 if owner UART, 8'h5A if owner TOUR; pulse tour_resp only if owner TOUR and not timeout; return to IDLE.
REQ-029 resp holds its last value outside RESP.
REQ-030 Minimum spacing: a new grant occurs no earlier than the cycle after RESP.
REQ-031 tour_active falling mid-BUSY does not abort the current command; ownership unchanged until RESP.
REQ-032 clr_cmd_rdy in IDLE, BUSY or RESP is ignored.

Reset
REQ-033 rst_n low at a clock edge: state IDLE, cmd 16'h0000, resp 8'h00, cmd_rdy, trmt, tour_resp, clr_uart_cmd_rdy, clr_tour_cmd_rdy, busy all 0, counter and timeout flag 0.
REQ-034 Reset mid-operation abandons the current command; no trmt or tour_resp is issued for it.

Verification
REQ-035 uart_cmd=16'h2000, uart_cmd_rdy=1, tour_active=0 -> clr_uart_cmd_rdy 1-cycle pulse, cmd=16'h2000, cmd_rdy=1; clr_cmd_rdy then send_resp -> trmt pulse, resp=8'hA5, tour_resp=0.
REQ-036 Both ready same cycle (uart 16'h2000, tour 16'h4002), tour_active=1 -> cmd=16'h4002, only clr_tour_cmd_rdy pulses; after send_resp: resp=8'h5A, tour_resp pulse; UART request still pending and ungranted while tour_active=1.
REQ-037 Drop tour_active with uart_cmd_rdy still high -> UART granted on next IDLE cycle.
REQ-038 FAST_SIM=1, no send_resp after clr_cmd_rdy -> after 65536 BUSY cycles trmt pulse with resp=8'hEE, tour_resp=0, busy=0 next cycle.
REQ-039 Assert rst_n=0 in GRANT and in BUSY -> next cycle all outputs at reset values; later send_resp produces no trmt.
REQ-040 send_resp and clr_cmd_rdy pulsed in IDLE -> no state change, no output pulses.
